// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared state encoding and helpers for the pipeline skid stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [1:0] state_count(input state_t s);
    logic [1:0] c_cnt;
    case (s)
      ONE:     c_cnt = 2'd1;
      FULL:    c_cnt = 2'd2;
      default: c_cnt = 2'd0;
    endcase
    return c_cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Purpose  : WIDTH-bit payload register with load enable, async reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Two-entry valid/ready skid buffer with fully registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_count;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_load;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  always_comb begin
    w_in_xfer   = in_valid && r_in_ready;
    w_out_xfer  = r_out_valid && out_ready;
    w_state_nxt = r_state;
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_d    = in_data;
    // Flush overrides everything; slot contents are left as-is.
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_main_load = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          case ({w_in_xfer, w_out_xfer})
            2'b10: begin
              w_skid_load = 1'b1;
              w_state_nxt = FULL;
            end
            2'b01: w_state_nxt = EMPTY;
            2'b11: w_main_load = 1'b1;
            default: w_state_nxt = ONE;
          endcase
        end
        FULL: begin
          if (w_out_xfer) begin
            w_main_load = 1'b1;
            w_main_d    = w_skid_q;
            w_state_nxt = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_count     <= state_count(w_state_nxt);
    end
  end

  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_data (w_main_d),
    .o_data (w_main_q)
  );

  pipe_slot #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_data (in_data),
    .o_data (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Scoreboard bench for pipe_skid_stage against a 2-deep queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             flush = 1'b0;
  logic [1:0]       count;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] q[$];
  int               pre_size = 0;
  bit               armed = 1'b0;

  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Model: the stage is a queue of at most two words; ready only after one clean edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      armed = 1'b0;
      q.delete();
    end else begin
      armed = 1'b1;
    end
  end

  // Monitor: checks status against the model and pops on each downstream transfer.
  always begin
    @(negedge clk);
    #1;
    pre_size = q.size();
    chk("in_ready", 32'(in_ready), 32'(armed && pre_size < 2));
    chk("out_valid", 32'(out_valid), 32'(pre_size > 0));
    chk("count", 32'(count), 32'(pre_size));
    if (pre_size > 0) begin
      chk("out_data", out_data, q[0]);
      if (out_ready) void'(q.pop_front());
    end
  end

  // Stimulus side of the scoreboard: pushes accepted words, flush empties the model.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (flush) q.delete();
      else if (in_valid && armed && pre_size < 2) q.push_back(in_data);
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    #3 chk("ready_after_reset", 32'(in_ready), 32'd1);

    for (int i = 1; i <= 16; i++) drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    #3 chk("bp_count", 32'(count), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 32'hC, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    drive(1'b1, 32'h5, 1'b0, 1'b0);
    drive(1'b1, 32'h6, 1'b0, 1'b0);
    drive(1'b1, 32'h7, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    #3 chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h12, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 2);
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits.
REQ-002 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1: upstream offers in_data this cycle.
REQ-005 SHALL have port in_ready  output  1: stage can accept a word this cycle.
REQ-006 SHALL have port in_data  input  WIDTH: upstream payload.
REQ-007 SHALL have port out_valid  output  1: out_data holds a valid word.
REQ-008 SHALL have port out_ready  input  1: downstream consumes out_data this cycle.
REQ-009 SHALL have port out_data  output  WIDTH: head-of-stage payload.
REQ-010 SHALL have port flush  input  1: synchronous discard of all held words.
REQ-011 SHALL have port count  output  2: number of held words, 0..2.

Function
REQ-012 SHALL hold at most two words: a main slot (drives out_data) and a skid slot.
REQ-013 SHALL implement states EMPTY (0 words), ONE (main only), FULL (main+skid); count SHALL equal 0/1/2 respectively.
REQ-014 SHALL treat a transfer in as in_valid && in_ready, a transfer out as out_valid && out_ready, sampled at rising clk.
REQ-015 SHALL drive in_ready, out_valid, out_data and count only from registers (no combinational in->out path).
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL.
REQ-017 SHALL drive out_valid = 1 in ONE and FULL and 0 in EMPTY.
REQ-018 EMPTY: transfer in -> main <= in_data, go ONE; first word on out_data one cycle after acceptance.
REQ-019 ONE: in only -> skid <= in_data, go FULL; out only -> go EMPTY; in and out together -> main <= in_data, stay ONE; neither -> hold.
REQ-020 FULL: out -> main <= skid, go ONE; no input accepted; no out -> hold all.
REQ-021 SHALL preserve word order: every accepted word appears on out_data exactly once, in acceptance order.
REQ-022 SHALL keep out_data stable while out_valid && !out_ready.
REQ-023 flush SHALL take priority over every other event: next edge goes EMPTY, any word offered in the flush cycle is discarded, and the downstream transfer in that cycle still counts as consumed.
REQ-024 SHALL keep slot contents unchanged, not cleared, when entering EMPTY; out_data is don't-care while out_valid = 0.
REQ-025 SHALL sustain one word per cycle when out_ready is held high.

Reset
REQ-026 rst SHALL asynchronously force state EMPTY, in_ready = 0, out_valid = 0, count = 0, out_data = 0, skid = 0.
REQ-027 SHALL raise in_ready on the first rising clk after rst deasserts, and accept no input while rst is high.
REQ-028 rst asserted mid-operation SHALL discard held words with no partial update on deassertion.

Structure
REQ-029 SHALL place the state enum (EMPTY, ONE, FULL) in shared package pipe_pkg.
REQ-030 SHALL use one sub-module, pipe_slot: WIDTH-bit register with load enable and async active-high reset to 0, instantiated twice (main, skid).
REQ-031 SHALL keep the next-state/handshake logic in a single always_comb plus one always_ff for state.

Verification
REQ-032 Reset: rst high 3 cycles, in_valid = 1 -> in_ready = 0, out_valid = 0, count = 0 throughout; in_ready = 1 on first edge after release.
REQ-033 Streaming: out_ready = 1, feed 0x1..0x10 back-to-back -> out_data 0x1..0x10 in order, each one cycle after acceptance, count stays 1.
REQ-034 Backpressure: out_ready = 0, offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, count = 2, in_ready = 0, 0xC held upstream; release out_ready -> 0xA, 0xB, 0xC emerge in order.
REQ-035 Flush with input: FULL holding 0x5, 0x6, assert flush with in_valid = 1, in_data = 0x7 -> next cycle count = 0, out_valid = 0, 0x7 never appears.
REQ-036 Async reset mid-stream: rst pulsed between edges while FULL -> out_valid, count drop to 0 immediately, before the next edge.
REQ-037 Random scoreboard: 10k cycles of random in_valid/out_ready/flush (flush at 2%) -> output sequence matches a reference queue model, with no loss, duplication or reorder.
